cache_controller: RTL and testbench

//  2-way set-associative, write-through, no-write-allocate cache controller between the MEM stage and the SRAM controller.

---
 rtl/cache_pkg.sv | 21 ++
 rtl/cache_way.sv | 47 ++++
 rtl/cache_controller.sv | 189 ++++++++++++++++++
 tb/tb_cache_controller.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// Shared definitions for the 2-way set-associative write-through cache controller:
// FSM state encoding, default geometry and address field offsets.
package cache_pkg;

  localparam int unsigned DefIndexW = 6;
  localparam int unsigned DefCntW   = 16;

  // Address layout: [2] word-in-line, [IndexLsb +: INDEX_W] set index, tag up to AddrMsb
  localparam int unsigned WordBit  = 2;
  localparam int unsigned IndexLsb = 3;
  localparam int unsigned AddrMsb  = 18;

  localparam int unsigned LineW = 64;

  typedef enum logic [1:0] {
    StIdle,
    StRdMiss,
    StWrThru
  } state_e;

endpackage

// File: rtl/cache_way.sv
// One way of the cache: per-set valid/tag/line storage, tag compare and fill/invalidate.
// Only valid bits are reset; tag and data arrays hold whatever was last filled.
module cache_way #(
  parameter int unsigned IndexW = 6,
  parameter int unsigned TagW   = 10,
  parameter int unsigned LineW  = 64
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [IndexW-1:0] index_i,
  input  logic [TagW-1:0]   tag_i,
  input  logic              fill_i,
  input  logic [LineW-1:0]  fill_data_i,
  input  logic              inval_i,
  output logic              valid_o,
  output logic              hit_o,
  output logic [LineW-1:0]  data_o
);

  localparam int unsigned Sets = 1 << IndexW;

  logic [Sets-1:0]  valid_q;
  logic [TagW-1:0]  tag_q  [Sets];
  logic [LineW-1:0] data_q [Sets];

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      valid_q <= '0;
    end else if (fill_i) begin
      valid_q[index_i] <= 1'b1;
    end else if (inval_i) begin
      valid_q[index_i] <= 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (fill_i && rst_ni) begin
      tag_q[index_i]  <= tag_i;
      data_q[index_i] <= fill_data_i;
    end
  end

  assign valid_o = valid_q[index_i];
  assign hit_o   = valid_o && (tag_q[index_i] == tag_i);
  assign data_o  = data_q[index_i];

endmodule

// File: rtl/cache_controller.sv
// 2-way set-associative, write-through, no-write-allocate cache between MEM stage and SRAM.
// Optional hit/miss statistics counters are enabled with `define CACHE_STATS_EN.
module cache_controller
  import cache_pkg::*;
#(
  parameter int unsigned INDEX_W = DefIndexW,
  parameter int unsigned TAG_W   = AddrMsb + 1 - IndexLsb - INDEX_W,
  parameter int unsigned CNT_W   = DefCntW
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             MEM_R_EN,
  input  logic             MEM_W_EN,
  input  logic [31:0]      address,
  input  logic [31:0]      writeData,
  output logic [31:0]      readData,
  output logic             pause,
  output logic             sram_we_n,
  output logic             sram_re_n,
  output logic [31:0]      sram_address,
  output logic [31:0]      sram_wdata,
  input  logic [63:0]      sram_rdata,
  input  logic             sram_ready,
  input  logic             sram_pause
`ifdef CACHE_STATS_EN
  ,
  output logic [CNT_W-1:0] hit_cnt,
  output logic [CNT_W-1:0] miss_cnt
`endif
);

  localparam int unsigned Sets   = 1 << INDEX_W;
  localparam int unsigned TagLsb = IndexLsb + INDEX_W;

  state_e state_q, state_d;

  logic [INDEX_W-1:0] index;
  logic [TAG_W-1:0]   tag;
  logic               word_sel;

  logic               valid0, valid1, hit0, hit1;
  logic [LineW-1:0]   data0, data1, hit_line;
  logic [31:0]        hit_word, fill_word;
  logic               fill0, fill1, inval0, inval1;
  logic               victim;
  logic               lru_upd, lru_val;
  logic [Sets-1:0]    lru_q;

  assign index    = address[IndexLsb +: INDEX_W];
  assign tag      = address[TagLsb +: TAG_W];
  assign word_sel = address[WordBit];

  assign sram_address = address;
  assign sram_wdata   = writeData;

  cache_way #(
    .IndexW (INDEX_W),
    .TagW   (TAG_W),
    .LineW  (LineW)
  ) u_way0 (
    .clk_i       (clk),
    .rst_ni      (rst),
    .index_i     (index),
    .tag_i       (tag),
    .fill_i      (fill0),
    .fill_data_i (sram_rdata),
    .inval_i     (inval0),
    .valid_o     (valid0),
    .hit_o       (hit0),
    .data_o      (data0)
  );

  cache_way #(
    .IndexW (INDEX_W),
    .TagW   (TAG_W),
    .LineW  (LineW)
  ) u_way1 (
    .clk_i       (clk),
    .rst_ni      (rst),
    .index_i     (index),
    .tag_i       (tag),
    .fill_i      (fill1),
    .fill_data_i (sram_rdata),
    .inval_i     (inval1),
    .valid_o     (valid1),
    .hit_o       (hit1),
    .data_o      (data1)
  );

  assign hit_line  = hit1 ? data1 : data0;
  assign hit_word  = word_sel ? hit_line[63:32] : hit_line[31:0];
  assign fill_word = word_sel ? sram_rdata[63:32] : sram_rdata[31:0];
  // Fill an empty way first (way0 preferred); otherwise replace the LRU way.
  assign victim    = !valid0 ? 1'b0 : (!valid1 ? 1'b1 : lru_q[index]);

  always_comb begin
    state_d   = state_q;
    pause     = 1'b0;
    sram_we_n = 1'b1;
    sram_re_n = 1'b1;
    readData  = '0;
    fill0     = 1'b0;
    fill1     = 1'b0;
    inval0    = 1'b0;
    inval1    = 1'b0;
    lru_upd   = 1'b0;
    lru_val   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (MEM_W_EN) begin
          sram_we_n = 1'b0;
          pause     = 1'b1;
          inval0    = hit0;
          inval1    = hit1;
          state_d   = StWrThru;
        end else if (MEM_R_EN) begin
          if (hit0 || hit1) begin
            readData = hit_word;
            lru_upd  = 1'b1;
            lru_val  = hit0;
          end else begin
            sram_re_n = 1'b0;
            pause     = 1'b1;
            state_d   = StRdMiss;
          end
        end
      end
      StRdMiss: begin
        sram_re_n = 1'b0;
        pause     = 1'b1;
        if (sram_ready) begin
          pause    = 1'b0;
          fill0    = !victim;
          fill1    = victim;
          lru_upd  = 1'b1;
          lru_val  = !victim;
          readData = fill_word;
          state_d  = StIdle;
        end
      end
      StWrThru: begin
        sram_we_n = 1'b0;
        pause     = 1'b1;
        if (!sram_pause) begin
          pause   = 1'b0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= StIdle;
      lru_q   <= '0;
    end else begin
      state_q <= state_d;
      if (lru_upd) begin
        lru_q[index] <= lru_val;
      end
    end
  end

`ifdef CACHE_STATS_EN
  logic [CNT_W-1:0] hit_cnt_q, miss_cnt_q;
  logic             hit_ev, miss_ev;

  assign hit_ev  = (state_q == StIdle) && MEM_R_EN && !MEM_W_EN && (hit0 || hit1);
  assign miss_ev = (state_q == StIdle) && MEM_R_EN && !MEM_W_EN && !(hit0 || hit1);

  always_ff @(posedge clk) begin
    if (!rst) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      if (hit_ev && (hit_cnt_q != '1)) hit_cnt_q <= hit_cnt_q + CNT_W'(1);
      if (miss_ev && (miss_cnt_q != '1)) miss_cnt_q <= miss_cnt_q + CNT_W'(1);
    end
  end

  assign hit_cnt  = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;
`else
  logic [CNT_W-1:0] stats_unused;
  assign stats_unused = '0;
`endif

endmodule

// File: tb/tb_cache_controller.sv
// Scoreboard bench for cache_controller: a recency-ordered 2-entry-per-set model predicts
// hits, misses, evictions and returned words; a monitor compares every accepted read.
module tb_cache_controller;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        MEM_R_EN = 1'b0, MEM_W_EN = 1'b0;
  logic [31:0] address = '0, writeData = '0;
  logic [31:0] readData;
  logic        pause, sram_we_n, sram_re_n;
  logic [31:0] sram_address, sram_wdata;
  logic [63:0] sram_rdata = '0;
  logic        sram_ready = 1'b0, sram_pause = 1'b0;
`ifdef CACHE_STATS_EN
  logic [15:0] hit_cnt, miss_cnt;
`endif

  always #5 clk = ~clk;

  cache_controller dut (
    .clk          (clk),
    .rst          (rst),
    .MEM_R_EN     (MEM_R_EN),
    .MEM_W_EN     (MEM_W_EN),
    .address      (address),
    .writeData    (writeData),
    .readData     (readData),
    .pause        (pause),
    .sram_we_n    (sram_we_n),
    .sram_re_n    (sram_re_n),
    .sram_address (sram_address),
    .sram_wdata   (sram_wdata),
    .sram_rdata   (sram_rdata),
    .sram_ready   (sram_ready),
    .sram_pause   (sram_pause)
`ifdef CACHE_STATS_EN
    ,
    .hit_cnt      (hit_cnt),
    .miss_cnt     (miss_cnt)
`endif
  );

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] exp_q[$];

  // Model: each set holds up to two lines; the least recently touched one is replaced.
  bit          mv  [64][2];
  bit [9:0]    mt  [64][2];
  bit [63:0]   md  [64][2];
  int unsigned mts [64][2];
  int unsigned now_t = 0;
  int          m_hits = 0, m_misses = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int model_find(input logic [31:0] a);
    int s = int'(a[8:3]);
    for (int w = 0; w < 2; w++) if (mv[s][w] && mt[s][w] == a[18:9]) return w;
    return -1;
  endfunction

  task automatic model_reset();
    for (int s = 0; s < 64; s++) begin
      mv[s][0] = 0;
      mv[s][1] = 0;
    end
    m_hits   = 0;
    m_misses = 0;
  endtask

  task automatic model_fill(input logic [31:0] a, input logic [63:0] line);
    int s = int'(a[8:3]);
    int w;
    if (!mv[s][0]) w = 0;
    else if (!mv[s][1]) w = 1;
    else w = (mts[s][0] < mts[s][1]) ? 0 : 1;
    mv[s][w]  = 1;
    mt[s][w]  = a[18:9];
    md[s][w]  = line;
    mts[s][w] = ++now_t;
  endtask

  // Every read accepted by the pipeline (read, no write, not paused) must match the queue head.
  always @(negedge clk) begin
    if (rst && MEM_R_EN && !MEM_W_EN && !pause) begin
      if (exp_q.size() == 0) begin
        check("unexpected_read_response", 64'(readData), 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        check("readData", 64'(readData), 64'(exp_q.pop_front()));
      end
    end
  end

  task automatic do_idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      MEM_R_EN = 0; MEM_W_EN = 0; sram_ready = 0; sram_pause = 0;
      @(negedge clk);
      check("idle_pause", pause, 0);
      check("idle_we_n", sram_we_n, 1);
      check("idle_re_n", sram_re_n, 1);
    end
  endtask

  task automatic do_read(input logic [31:0] a);
    int s = int'(a[8:3]);
    int w = model_find(a);
    logic [63:0] line;
    int waitc;
    @(posedge clk); #1;
    MEM_R_EN = 1; MEM_W_EN = 0; address = a; sram_ready = 0; sram_pause = 0;
    if (w >= 0) begin
      exp_q.push_back(a[2] ? md[s][w][63:32] : md[s][w][31:0]);
      mts[s][w] = ++now_t;
      m_hits++;
      @(negedge clk);
      check("hit_pause", pause, 0);
      check("hit_re_n", sram_re_n, 1);
      check("hit_we_n", sram_we_n, 1);
    end else begin
      line = {$urandom, $urandom};
      exp_q.push_back(a[2] ? line[63:32] : line[31:0]);
      model_fill(a, line);
      m_misses++;
      @(negedge clk);
      check("miss_pause", pause, 1);
      check("miss_re_n", sram_re_n, 0);
      check("miss_we_n", sram_we_n, 1);
      check("miss_addr", sram_address, a);
      waitc = $urandom_range(0, 3);
      for (int i = 0; i < waitc; i++) begin
        @(posedge clk); #1;
        sram_rdata = {$urandom, $urandom};
        @(negedge clk);
        check("miss_wait_re_n", sram_re_n, 0);
        check("miss_wait_pause", pause, 1);
      end
      @(posedge clk); #1;
      sram_ready = 1; sram_rdata = line;
      @(negedge clk);
      check("fill_pause", pause, 0);
    end
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic both);
    int w = model_find(a);
    int waitc;
    @(posedge clk); #1;
    MEM_W_EN = 1; MEM_R_EN = both; address = a; writeData = d; sram_ready = 0; sram_pause = 1;
    if (w >= 0) mv[int'(a[8:3])][w] = 0;
    @(negedge clk);
    check("wr_we_n", sram_we_n, 0);
    check("wr_re_n", sram_re_n, 1);
    check("wr_pause", pause, 1);
    check("wr_wdata", sram_wdata, d);
    check("wr_addr", sram_address, a);
    waitc = $urandom_range(0, 3);
    for (int i = 0; i < waitc; i++) begin
      @(posedge clk); #1;
      @(negedge clk);
      check("wr_wait_we_n", sram_we_n, 0);
      check("wr_wait_re_n", sram_re_n, 1);
      check("wr_wait_pause", pause, 1);
    end
    @(posedge clk); #1;
    sram_pause = 0;
    @(negedge clk);
    check("wr_done_pause", pause, 0);
    check("wr_done_we_n", sram_we_n, 0);
  endtask

  task automatic do_reset_abort(input logic [31:0] a);
    @(posedge clk); #1;
    MEM_R_EN = 1; MEM_W_EN = 0; address = a; sram_ready = 0; sram_pause = 0;
    @(negedge clk);
    check("abort_miss_re_n", sram_re_n, 0);
    @(posedge clk); #1;
    @(negedge clk);
    check("abort_wait_re_n", sram_re_n, 0);
    @(posedge clk); #1;
    rst = 0; MEM_R_EN = 0;
    @(posedge clk); #1;
    rst = 1; sram_ready = 1; sram_rdata = {$urandom, $urandom};
    model_reset();
    @(negedge clk);
    check("abort_re_n_released", sram_re_n, 1);
    check("abort_pause", pause, 0);
  endtask

  initial begin
    logic [31:0] a;
    int r;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1;
    @(negedge clk);
    check("reset_pause", pause, 0);
    check("reset_we_n", sram_we_n, 1);
    check("reset_re_n", sram_re_n, 1);
`ifdef CACHE_STATS_EN
    check("reset_hit_cnt", hit_cnt, 0);
    check("reset_miss_cnt", miss_cnt, 0);
`endif

    do_read(32'h0000_0400);                 // cold miss, word0
    do_read(32'h0000_0404);                 // hit, word1
    do_read(32'h0000_0200);                 // tag 1 into set 0
    do_read(32'h0000_0200);
    do_read(32'h0000_0600);                 // tag 3 evicts tag 2
    do_read(32'h0000_0204);                 // tag 1 survives
    do_read(32'h0000_0400);                 // tag 2 refetched
    do_read(32'h0000_0400);
    do_write(32'h0000_0400, 32'hDEAD_BEEF, 1'b0);
    do_idle(1);
    do_read(32'h0000_0400);                 // invalidated by the write
    do_write(32'h0000_0200, $urandom, 1'b1); // both enables: write wins
    do_read(32'h0000_0200);
    do_reset_abort(32'h0000_1008);
    do_read(32'h0000_1008);                 // must miss after aborted fill

    for (int i = 0; i < 400; i++) begin
      a = {$urandom} & 32'hFFF8_0003;
      a[18:9] = 10'($urandom_range(0, 3));
      a[8:3]  = 6'($urandom_range(0, 3));
      a[2]    = 1'($urandom_range(0, 1));
      r = $urandom_range(0, 99);
      if (r < 78) do_read(a);
      else if (r < 94) do_write(a, $urandom, 1'($urandom_range(0, 1)));
      else do_idle(1);
    end
    do_idle(2);

    check("scoreboard_drained", 64'(exp_q.size()), 0);
`ifdef CACHE_STATS_EN
    check("hit_cnt", hit_cnt, 64'(m_hits));
    check("miss_cnt", miss_cnt, 64'(m_misses));
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
